// File: rtl/serial_mac.sv
// Serial multiply-accumulate engine: one signed product per enabled tap, summed over a frame,
// then rounded, scaled and saturated into a registered result with a one-cycle valid strobe.
module serial_mac #(
  parameter int FILTER_IN_BITS  = 16,
  parameter int COEFF_BITS      = 16,
  parameter int FILTER_OUT_BITS = 16,
  parameter int NUMBER_OF_TAPS  = 64,
  parameter int OUT_SHIFT       = 15,
  localparam int COUNTER_BITS   = $clog2(NUMBER_OF_TAPS),
  localparam int ACC_BITS       = FILTER_IN_BITS + COEFF_BITS + COUNTER_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_enable,
  input  logic                       phase_min,
  input  logic [COUNTER_BITS-1:0]    current_count,
  input  logic [FILTER_IN_BITS-1:0]  delay_filter_in,
  input  logic [COEFF_BITS-1:0]      coeff,
  output logic [FILTER_OUT_BITS-1:0] filter_out,
  output logic                       filter_out_valid,
  output logic                       filter_out_sat
);

  localparam int PROD_BITS = FILTER_IN_BITS + COEFF_BITS;
  localparam int RND_BITS  = ACC_BITS + 1;
  localparam logic [COUNTER_BITS-1:0] LAST_IDX = COUNTER_BITS'(NUMBER_OF_TAPS - 1);
  localparam logic signed [RND_BITS-1:0] ROUND_BIAS =
    (OUT_SHIFT == 0) ? '0 : RND_BITS'(1) << ((OUT_SHIFT == 0) ? 0 : OUT_SHIFT - 1);
  localparam logic signed [RND_BITS-1:0] OUT_MAX =
    RND_BITS'((64'sd1 <<< (FILTER_OUT_BITS - 1)) - 64'sd1);
  localparam logic signed [RND_BITS-1:0] OUT_MIN = ~OUT_MAX;

  // One guard bit above the accumulator absorbs the rounding bias.
  function automatic logic signed [RND_BITS-1:0] round_shift(
    input logic signed [ACC_BITS-1:0] v
  );
    logic signed [RND_BITS-1:0] w;
    w = RND_BITS'(v) + ROUND_BIAS;
    return w >>> OUT_SHIFT;
  endfunction

  // Returns {clipped, value}.
  function automatic logic [FILTER_OUT_BITS:0] saturate(
    input logic signed [RND_BITS-1:0] v
  );
    if (v > OUT_MAX) return {1'b1, OUT_MAX[FILTER_OUT_BITS-1:0]};
    if (v < OUT_MIN) return {1'b1, OUT_MIN[FILTER_OUT_BITS-1:0]};
    return {1'b0, v[FILTER_OUT_BITS-1:0]};
  endfunction

  logic signed [PROD_BITS-1:0] prod_p0;
  logic signed [PROD_BITS-1:0] prod_p1;
  logic                        vld_p1;
  logic                        first_p1;
  logic                        last_p1;
  logic signed [ACC_BITS-1:0]  acc;
  logic signed [ACC_BITS-1:0]  prod_ext_p1;
  logic signed [ACC_BITS-1:0]  sum_p1;
  logic                        in_frame;
  logic                        emit_p1;
  logic [FILTER_OUT_BITS:0]    sat_res_p1;

  always_comb begin
    prod_p0 = PROD_BITS'($signed(delay_filter_in)) * PROD_BITS'($signed(coeff));
  end

  // Stage 0 -> 1: capture tap flags and the product
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      prod_p1  <= '0;
    end else begin
      vld_p1   <= clk_enable;
      first_p1 <= clk_enable & phase_min;
      last_p1  <= clk_enable & (current_count == LAST_IDX);
      if (clk_enable) prod_p1 <= prod_p0;
    end
  end

  always_comb begin
    prod_ext_p1 = ACC_BITS'(prod_p1);
    sum_p1      = first_p1 ? prod_ext_p1 : acc + prod_ext_p1;
    emit_p1     = vld_p1 & last_p1 & (in_frame | first_p1);
    sat_res_p1  = saturate(round_shift(sum_p1));
  end

  // Stage 1 -> 2: accumulate, track the frame, register the scaled result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc              <= '0;
      in_frame         <= 1'b0;
      filter_out       <= '0;
      filter_out_valid <= 1'b0;
      filter_out_sat   <= 1'b0;
    end else begin
      if (vld_p1) begin
        if (last_p1) begin
          acc      <= '0;
          in_frame <= 1'b0;
        end else begin
          acc <= sum_p1;
          if (first_p1) in_frame <= 1'b1;
        end
      end
      filter_out_valid <= emit_p1;
      filter_out_sat   <= emit_p1 & sat_res_p1[FILTER_OUT_BITS];
      if (emit_p1) filter_out <= sat_res_p1[FILTER_OUT_BITS-1:0];
    end
  end

endmodule
